// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED blink scheduler: FSM states, default
// parameters and the lowest-index priority encoder used by the arbiter.
package led_sched_pkg;

   localparam int DEF_NUM_REQ  = 3;
   localparam int DEF_PAT_W    = 8;
   localparam int DEF_TICK_DIV = 1000000;
   localparam int DEF_REPEATS  = 1;

   // Widest request vector the encoder handles; callers zero-extend into it.
   localparam int MAX_REQ = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      FIN  = 2'd2
   } state_e;

   typedef struct packed {
      logic               any;
      logic [4:0]         idx;
      logic [MAX_REQ-1:0] onehot;
   } prio_t;

   function automatic prio_t prio_enc(input logic [MAX_REQ-1:0] req);
      prio_t r;
      r = '0;
      for (int i = MAX_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            r.any       = 1'b1;
            r.idx       = 5'(i);
            r.onehot    = '0;
            r.onehot[i] = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Bit-period prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// clear_i holds the count at zero so a new pattern starts on a full bit.
module led_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear_i,
   output logic tick_o
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one LED between NUM_REQ requesters; the granted pattern plays MSB-first
// REPEATS times, then DONE pulses. Define LED_SCHED_PREEMPT_EN for pre-emption.
module led_blink_scheduler
   import led_sched_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int PAT_W    = DEF_PAT_W,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int REPEATS  = DEF_REPEATS
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       REQ,
   input  logic [NUM_REQ*PAT_W-1:0] PATTERN,
   output logic [NUM_REQ-1:0]       GRANT,
   output logic [NUM_REQ-1:0]       DONE,
   output logic                     BUSY,
   output logic                     LED
);

   localparam int BW = $clog2(PAT_W + 1);
   localparam int RW = $clog2(REPEATS + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEATS - 1);

   state_e             state_q;
   logic [NUM_REQ-1:0] grant_q, done_q;
   logic               busy_q, led_q;
   logic [PAT_W-1:0]   pat_q, sh_q;
   logic [BW-1:0]      bit_q;
   logic [RW-1:0]      rep_q;

   logic               tick, tick_clr, owner_req, preempt;
   prio_t              arb;
   logic [PAT_W-1:0]   pat_arb;
   logic               unused_arb;

   always_comb arb = prio_enc(MAX_REQ'(REQ));
   assign unused_arb = ^arb;

   always_comb begin
      pat_arb = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (arb.onehot[i]) pat_arb = PATTERN[i*PAT_W +: PAT_W];
   end

   assign owner_req = |(REQ & grant_q);

`ifdef LED_SCHED_PREEMPT_EN
   prio_t              pre;
   logic [PAT_W-1:0]   pat_pre;
   logic               unused_pre;

   // grant_q - 1 turns the one-hot owner into a mask of higher-priority requesters.
   always_comb pre = prio_enc(MAX_REQ'(REQ & (grant_q - 1'b1)));
   assign unused_pre = ^pre;

   always_comb begin
      pat_pre = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pre.onehot[i]) pat_pre = PATTERN[i*PAT_W +: PAT_W];
   end

   assign preempt = (state_q == PLAY) && owner_req && pre.any;
`else
   assign preempt = 1'b0;
`endif

   assign tick_clr = (state_q != PLAY) || !owner_req || preempt;

   led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLK    (CLK),
      .RST    (RST),
      .clear_i(tick_clr),
      .tick_o (tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
         pat_q   <= '0;
         sh_q    <= '0;
         bit_q   <= '0;
         rep_q   <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (arb.any) begin
                  state_q <= PLAY;
                  grant_q <= arb.onehot[NUM_REQ-1:0];
                  busy_q  <= 1'b1;
                  pat_q   <= pat_arb;
                  sh_q    <= pat_arb;
                  led_q   <= pat_arb[PAT_W-1];
                  bit_q   <= '0;
                  rep_q   <= '0;
               end
            end
            PLAY: begin
               if (!owner_req) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  led_q   <= 1'b0;
                  bit_q   <= '0;
                  rep_q   <= '0;
               end
`ifdef LED_SCHED_PREEMPT_EN
               else if (preempt) begin
                  grant_q <= pre.onehot[NUM_REQ-1:0];
                  pat_q   <= pat_pre;
                  sh_q    <= pat_pre;
                  led_q   <= pat_pre[PAT_W-1];
                  bit_q   <= '0;
                  rep_q   <= '0;
               end
`endif
               else if (tick) begin
                  if (bit_q == BIT_LAST) begin
                     bit_q <= '0;
                     if (rep_q == REP_LAST) begin
                        state_q <= FIN;
                        done_q  <= grant_q;
                        led_q   <= 1'b0;
                     end else begin
                        rep_q <= rep_q + 1'b1;
                        sh_q  <= pat_q;
                        led_q <= pat_q[PAT_W-1];
                     end
                  end else begin
                     bit_q <= bit_q + 1'b1;
                     sh_q  <= {sh_q[PAT_W-2:0], sh_q[PAT_W-1]};
                     led_q <= sh_q[PAT_W-2];
                  end
               end
            end
            FIN: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               rep_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               led_q   <= 1'b0;
            end
         endcase
      end
   end

   assign GRANT = grant_q;
   assign DONE  = done_q;
   assign BUSY  = busy_q;
   assign LED   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Bench for led_blink_scheduler: table vectors, directed corner sequences and
// a randomized run against an elapsed-time reference model.
module tb_led_blink_scheduler;

   localparam int NR    = 3;
   localparam int PW    = 8;
   localparam int TD    = 4;
   localparam int TOTAL = PW * TD;

   logic           CLK = 1'b0;
   logic           RST;
   logic [NR-1:0]  REQ, REQ2;
   logic [NR*PW-1:0] PATTERN, PAT2;
   logic [NR-1:0]  GRANT, DONE, GRANT2, DONE2;
   logic           BUSY, LED, BUSY2, LED2;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always #5 CLK = ~CLK;

   led_blink_scheduler #(.NUM_REQ(NR), .PAT_W(PW), .TICK_DIV(TD), .REPEATS(1)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .PATTERN(PATTERN),
      .GRANT(GRANT), .DONE(DONE), .BUSY(BUSY), .LED(LED));

   led_blink_scheduler #(.NUM_REQ(NR), .PAT_W(PW), .TICK_DIV(TD), .REPEATS(2)) dut2 (
      .CLK(CLK), .RST(RST), .REQ(REQ2), .PATTERN(PAT2),
      .GRANT(GRANT2), .DONE(DONE2), .BUSY(BUSY2), .LED(LED2));

   // Reference model: 0 idle, 1 playing, 2 finishing; m_k = PLAY clocks elapsed.
   int          m_st = 0;
   int          m_own = 0;
   int          m_k = 0;
   logic [PW-1:0] m_pat = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h want %h", name, cycle, act, exp);
      end
   endtask

   function automatic int lowest(input logic [NR-1:0] r, input int lim);
      for (int i = 0; i < lim; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      int j;
      if (RST) begin
         m_st = 0; m_own = 0; m_k = 0;
      end else begin
         case (m_st)
            0: begin
               j = lowest(REQ, NR);
               if (j >= 0) begin
                  m_st = 1; m_own = j; m_pat = PATTERN[j*PW +: PW]; m_k = 0;
               end
            end
            1: begin
               if (!REQ[m_own]) m_st = 0;
               else begin
`ifdef LED_SCHED_PREEMPT_EN
                  j = lowest(REQ, m_own);
                  if (j >= 0) begin
                     m_own = j; m_pat = PATTERN[j*PW +: PW]; m_k = 0;
                  end else
`endif
                  begin
                     m_k++;
                     if (m_k == TOTAL) m_st = 2;
                  end
               end
            end
            default: m_st = 0;
         endcase
      end
   endtask

   function automatic logic [2*NR+1:0] exp_out();
      logic [NR-1:0] g, d;
      logic b, l;
      g = (m_st != 0) ? NR'(1 << m_own) : '0;
      d = (m_st == 2) ? NR'(1 << m_own) : '0;
      b = (m_st != 0);
      l = (m_st == 1) ? m_pat[PW - 1 - ((m_k / TD) % PW)] : 1'b0;
      return {g, d, b, l};
   endfunction

   task automatic cyc();
      @(posedge CLK);
      model_step();
      #1;
      cycle++;
      check("model", 32'({GRANT, DONE, BUSY, LED}), 32'(exp_out()));
   endtask

   typedef struct {
      logic [NR-1:0]    req;
      logic [NR*PW-1:0] pat;
      logic [NR-1:0]    g;
      logic             led;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int n, done_at, lat;
      logic [PW-1:0] p;

      tbl[0] = '{3'b001, {8'h00, 8'h00, 8'hA5}, 3'b001, 1'b1};
      tbl[1] = '{3'b110, {8'h00, 8'h7F, 8'h00}, 3'b010, 1'b0};
      tbl[2] = '{3'b100, {8'h80, 8'h00, 8'h00}, 3'b100, 1'b1};
      tbl[3] = '{3'b111, {8'hFF, 8'hFF, 8'h01}, 3'b001, 1'b0};
      tbl[4] = '{3'b011, {8'h00, 8'h80, 8'h7F}, 3'b001, 1'b0};
      tbl[5] = '{3'b101, {8'hFF, 8'h00, 8'h80}, 3'b001, 1'b1};

      RST = 1'b1; REQ = '0; PATTERN = '0; REQ2 = '0; PAT2 = '0;
      cyc(); cyc();
      check("reset", 32'({GRANT, DONE, BUSY, LED}), 32'd0);
      check("reset2", 32'({GRANT2, DONE2, BUSY2, LED2}), 32'd0);
      RST = 1'b0;
      cyc();

      // Arbitration from idle, then abort back to idle.
      for (int i = 0; i < 6; i++) begin
         REQ = tbl[i].req; PATTERN = tbl[i].pat;
         cyc();
         check("tbl_grant", 32'(GRANT), 32'(tbl[i].g));
         check("tbl_led", 32'(LED), 32'(tbl[i].led));
         check("tbl_busy", 32'(BUSY), 32'd1);
         REQ = '0;
         cyc();
         check("tbl_abort", 32'({GRANT, BUSY, LED}), 32'd0);
      end

      // Full play of 0xA5; PATTERN is scrambled mid-play and must not matter.
      p = 8'hA5;
      REQ = 3'b001; PATTERN = {8'h00, 8'h00, p};
      done_at = 0;
      for (n = 1; n <= 40; n++) begin
         cyc();
         if (n == 1) check("a5_grant", 32'(GRANT), 32'b001);
         if (n == 5) PATTERN = {8'h5A, 8'h5A, 8'h00};
         if (n <= 32) check("a5_led", 32'(LED), 32'(p[7 - (n - 1) / TD]));
         if (DONE != '0) begin done_at = n; break; end
      end
      check("a5_done_lat", 32'(done_at), 32'd33);
      check("a5_done", 32'(DONE), 32'b001);
      check("a5_fin_led", 32'(LED), 32'd0);
      REQ = '0;
      cyc();
      check("a5_idle", 32'(GRANT), 32'd0);

      // Two requesters: 0 first, 2 granted two clocks after DONE[0].
      REQ = 3'b101; PATTERN = {8'h3C, 8'h00, 8'hA5};
      cyc();
      check("pair_first", 32'(GRANT), 32'b001);
      for (n = 0; n < 40 && DONE == '0; n++) cyc();
      check("pair_done0", 32'(DONE), 32'b001);
      REQ = 3'b100;
      lat = 0;
      for (n = 1; n <= 5; n++) begin
         cyc();
         if (GRANT == 3'b100) begin lat = n; break; end
      end
      check("pair_second_lat", 32'(lat), 32'd2);
      REQ = '0;
      cyc(); cyc();

      // Owner drops REQ on PLAY clock 10.
      REQ = 3'b010; PATTERN = {8'h00, 8'hFF, 8'h00};
      cyc();
      repeat (10) cyc();
      check("abort_led_on", 32'(LED), 32'd1);
      REQ = '0;
      cyc();
      check("abort_out", 32'({GRANT, DONE, BUSY, LED}), 32'd0);
      cyc();
      check("abort_nodone", 32'(DONE), 32'd0);

      // Reset mid-play with REQ still high.
      REQ = 3'b001; PATTERN = {8'h00, 8'h00, 8'hFF};
      cyc();
      repeat (5) cyc();
      RST = 1'b1;
      cyc();
      check("rst_play", 32'({GRANT, DONE, BUSY, LED}), 32'd0);
      RST = 1'b0;
      cyc();
      check("rst_regrant", 32'(GRANT), 32'b001);
      REQ = '0;
      cyc(); cyc();

      // Higher-priority request arrives on PLAY clock 6.
      REQ = 3'b100; PATTERN = {8'h0F, 8'h00, 8'hC3};
      cyc();
      repeat (6) cyc();
      REQ = 3'b101;
      cyc();
`ifdef LED_SCHED_PREEMPT_EN
      check("pre_grant", 32'(GRANT), 32'b001);
      check("pre_led", 32'(LED), 32'd1);
`else
      check("pre_grant", 32'(GRANT), 32'b100);
      check("pre_led", 32'(LED), 32'd0);
`endif
      check("pre_nodone", 32'(DONE), 32'd0);
      REQ = '0;
      cyc(); cyc();

      // REPEATS=2 instance with 0x80.
      REQ2 = 3'b001; PAT2 = {8'h00, 8'h00, 8'h80};
      done_at = 0;
      for (n = 1; n <= 70; n++) begin
         cyc();
         if (n == 1) check("r2_grant", 32'({GRANT2, BUSY2}), 32'({3'b001, 1'b1}));
         if (n <= 64) check("r2_led", 32'(LED2), 32'(((n - 1) % 32) < TD));
         if (DONE2 != '0) begin done_at = n; break; end
      end
      check("r2_done_lat", 32'(done_at), 32'd65);
      check("r2_done", 32'(DONE2), 32'b001);
      REQ2 = '0;
      cyc();

      // Randomized traffic against the model.
      for (int t = 0; t < 3000; t++) begin
         for (int b = 0; b < NR; b++)
            if ($urandom_range(0, 39) == 0) REQ[b] = ~REQ[b];
         PATTERN = 24'($urandom);
         RST = ($urandom_range(0, 499) == 0);
         cyc();
      end
      RST = 1'b0; REQ = '0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_blink_scheduler.md
Name: led_blink_scheduler

Overview:
- Shares the single board LED between NUM_REQ requesters.
- Each requester submits a PAT_W-bit blink pattern. A fixed-priority arbiter grants one requester at a time.
- The granted pattern plays MSB-first, one bit per TICK_DIV clocks, REPEATS times, then the requester gets a DONE pulse.
- Replaces the free-running blinker as the LED's owner in the top level.

Parameters:
- NUM_REQ, 3, number of requesters.
- PAT_W, 8, pattern length in bits.
- TICK_DIV, 1000000, clocks per pattern bit (must be ≥2).
- REPEATS, 1, plays per grant (must be ≥1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NUM_REQ  level request per requester; held until DONE.
- PATTERN  in  NUM_REQ*PAT_W  requester i's pattern occupies bits [i*PAT_W +: PAT_W]; sampled only at grant.
- GRANT  out  NUM_REQ  one-hot owner; all zero when idle.
- DONE  out  NUM_REQ  one-cycle completion pulse to the owner.
- BUSY  out  1  high in PLAY and DONE states.
- LED  out  1  LED drive.

Behaviour:
- Reset: state IDLE. GRANT, DONE, BUSY and LED are 0. All counters are 0. Reset has priority over every other event.
- States: IDLE, PLAY, FIN.
- IDLE:
  - If any REQ bit is high, the lowest index i wins.
  - At the next edge: state becomes PLAY, GRANT=onehot(i), PATTERN slice i is latched into a shift register, and the tick, bit and repeat counters clear.
  - Latency from REQ high to GRANT/LED valid is 1 clock.
- PLAY:
  - LED = shift register MSB.
  - The tick counter counts 0..TICK_DIV-1. On the wrap the bit counter advances and the pattern rotates left.
  - After PAT_W bits, the repeat counter increments and the latched pattern is reloaded.
  - After REPEATS full passes, go to FIN. PLAY lasts exactly PAT_W*TICK_DIV*REPEATS clocks.
- FIN (one clock):
  - DONE[i]=1, GRANT held, LED=0.
  - Next edge: IDLE with GRANT=0.
  - If REQ[i] is still high in IDLE, it is re-arbitrated normally and may replay.
- Abort:
  - If REQ[owner] falls during PLAY, the next edge enters IDLE. GRANT=0, LED=0, no DONE pulse.
  - A new grant needs one further IDLE cycle.
- Non-owner REQ changes during PLAY are ignored.
- PATTERN changes after grant have no effect.
- Counter widths: $clog2(TICK_DIV), $clog2(PAT_W+1), $clog2(REPEATS+1). Comparisons are unsigned; no truncation beyond those widths.
- GRANT and DONE are never more than one-hot.

Optional Feature:
- Macro: LED_SCHED_PREEMPT_EN.
- Defined:
  - In PLAY, a REQ[j] high with j < owner index pre-empts at the next edge. GRANT becomes onehot(j), pattern j is latched and all counters clear.
  - The pre-empted requester gets no DONE. If it keeps REQ high, it is re-granted later from bit 0.
- Undefined: grants are non-pre-emptive; the arbiter is evaluated only in IDLE.

Decomposition:
- Package led_sched_pkg holds:
  - the state enum (IDLE, PLAY, FIN);
  - the default parameter constants;
  - a lowest-index priority-encode function returning the one-hot vector and the index.
- Sub-module led_tick_gen: prescaler with inputs CLK, RST, clear; outputs a one-cycle tick on the wrap.

Test Plan (TICK_DIV=4, PAT_W=8, REPEATS=1 unless stated):
- REQ=001, pattern0=0xA5 -> GRANT=001 one clock later; LED=1,0,1,0,0,1,0,1 each for 4 clocks; DONE=001 on clock 33 after grant, for 1 clock; then GRANT=000.
- REQ=101 together, drop REQ0 after DONE[0] -> GRANT=001 first; GRANT=100 two clocks after DONE[0].
- REQ=010 with pattern1=0xFF, drop REQ1 on PLAY clock 10 -> next edge GRANT=000, LED=0, DONE stays 000.
- RST high for 1 clock during PLAY -> next edge GRANT, DONE, BUSY and LED all 0; a new REQ is granted only after RST falls.
- REPEATS=2, pattern=0x80 -> LED high 4 clocks, low 28, high 4, low 28; DONE after 64 PLAY clocks.
- LED_SCHED_PREEMPT_EN, REQ2 playing, REQ0 rises on PLAY clock 6 -> next edge GRANT=001, LED follows pattern0 from bit 7, no DONE[2]. Without the macro, GRANT stays 100 until FIN.
